// File: rtl/target_path_planner_pkg.sv
// ---------------------------------------------------------------------------
// target_pkg
// Purpose : Definitions shared by the target path planner and its polar
//           delta helper. The package holds the angle resolution, the layout
//           of the 12-bit polar location word, the rover command encodings
//           and the planner state enumeration.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package target_pkg;

  // One full revolution is 24 theta positions of 15 degrees each.
  localparam int THETA_UNITS = 24;

  // Field widths and slice positions of a polar location word {theta, r}.
  localparam int LOC_W     = 12;
  localparam int THETA_W   = 5;
  localparam int R_W       = 7;
  localparam int THETA_MSB = 11;
  localparam int THETA_LSB = 7;
  localparam int R_MSB     = 6;
  localparam int R_LSB     = 0;

  // Sized copies of the revolution so comparisons stay width-matched.
  localparam logic [THETA_W-1:0] THETA_LIMIT = THETA_W'(THETA_UNITS);
  localparam logic [THETA_W-1:0] THETA_HALF  = THETA_W'(THETA_UNITS / 2);

  // Command codes carried on cmd_type toward the IR transmitter.
  typedef enum logic [1:0] {
    CMD_TURN_LEFT  = 2'b00,
    CMD_TURN_RIGHT = 2'b01,
    CMD_DRIVE_FWD  = 2'b10,
    CMD_DRIVE_REV  = 2'b11
  } cmd_type_e;

  // Planner sequencing: plan, emit turn, emit drive, wait for the locator,
  // then judge the result.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SEND_TURN,
    ST_SEND_DRIVE,
    ST_WAIT_MEAS,
    ST_CHECK
  } state_e;

  // Extract the theta index from a location word.
  function automatic logic [THETA_W-1:0] loc_theta(input logic [LOC_W-1:0] loc);
    return loc[THETA_MSB:THETA_LSB];
  endfunction

  // Extract the radius in inches from a location word.
  function automatic logic [R_W-1:0] loc_r(input logic [LOC_W-1:0] loc);
    return loc[R_MSB:R_LSB];
  endfunction

endpackage

// File: rtl/target_path_planner_polar_delta.sv
// ---------------------------------------------------------------------------
// polar_delta
// Purpose : Combinational angle arithmetic on the 24-position theta circle.
//           Given the wanted theta and the current theta it produces the
//           modular delta, which way to turn and by how much, and the
//           circular distance between the two angles.
// Ports   : target_theta_i  - wanted theta index
//           current_theta_i - present theta index (heading or measured)
//           delta_o         - (target - current) mod THETA_UNITS
//           turn_left_o     - 1 when the shorter turn is to the left
//           turn_mag_o      - turn amount in theta units (0 when aligned)
//           circ_dist_o     - min(delta, THETA_UNITS - delta)
// ---------------------------------------------------------------------------
module polar_delta
  import target_pkg::*;
(
  input  logic [THETA_W-1:0] target_theta_i,
  input  logic [THETA_W-1:0] current_theta_i,
  output logic [THETA_W-1:0] delta_o,
  output logic               turn_left_o,
  output logic [THETA_W-1:0] turn_mag_o,
  output logic [THETA_W-1:0] circ_dist_o
);

  localparam logic signed [6:0] UNITS_S = 7'(THETA_UNITS);

  logic signed [6:0] diff;

  // The raw difference spans -31..31 because a 5-bit current theta may be
  // out of range; two conditional wraps upward and one downward always land
  // it in 0..THETA_UNITS-1, so the turn amount can never exceed a half turn.
  always_comb begin
    diff = $signed({2'b00, target_theta_i}) - $signed({2'b00, current_theta_i});
    if (diff < 0) diff = diff + UNITS_S;
    if (diff < 0) diff = diff + UNITS_S;
    if (diff >= UNITS_S) diff = diff - UNITS_S;
    delta_o     = diff[THETA_W-1:0];
    turn_left_o = (delta_o != '0) && (delta_o <= THETA_HALF);
    if (delta_o == '0) begin
      turn_mag_o = '0;
    end else if (turn_left_o) begin
      turn_mag_o = delta_o;
    end else begin
      turn_mag_o = THETA_LIMIT - delta_o;
    end
    circ_dist_o = turn_mag_o;
  end

endmodule

// File: rtl/target_path_planner.sv
// ---------------------------------------------------------------------------
// target_path_planner
// Purpose : Turns a polar target location into rover motion commands (turn,
//           then drive), sends each over a valid/ready handshake, waits for
//           the ultrasound locator and decides arrived / retry / fail.
// Ports   : clock, reset      - clock and synchronous active-high reset
//           start             - pulse that begins a run (ignored while busy)
//           target_location   - {theta[11:7], r[6:0]}, latched on start
//           rover_location    - last measured rover position, same format
//           rover_heading     - rover heading in theta units
//           meas_valid        - pulse: new rover_location/rover_heading
//           cmd_ready         - transmitter accepts a command
//           cmd_valid/type/arg- outgoing command (held until accepted)
//           busy              - planner not idle
//           done / fail       - single-cycle result pulses
//           retry_count       - correction attempts used this run
// Config  : PLANNER_RETRY_EN - when defined a missed target triggers up to
//           MAX_RETRIES correction passes; otherwise a miss fails at once
//           and retry_count stays 0.
// ---------------------------------------------------------------------------
module target_path_planner
  import target_pkg::*;
#(
  parameter logic [26:0]        TIMEOUT_CYCLES = 27'd81_000_000,
  parameter logic [R_W-1:0]     R_TOL          = 7'd3,
  parameter logic [THETA_W-1:0] THETA_TOL      = 5'd1,
  parameter int unsigned        MAX_RETRIES    = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LOC_W-1:0] target_location,
  input  logic [LOC_W-1:0] rover_location,
  input  logic [THETA_W-1:0] rover_heading,
  input  logic             meas_valid,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [1:0]       cmd_type,
  output logic [R_W-1:0]   cmd_arg,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       retry_count
);

  state_e             state_q;
  logic [LOC_W-1:0]   tgt_q;
  logic [1:0]         retry_q;
  logic               cmd_valid_q;
  cmd_type_e          cmd_type_q;
  logic [R_W-1:0]     cmd_arg_q;
  cmd_type_e          drv_type_q;
  logic [R_W-1:0]     drv_arg_q;
  logic               done_q;
  logic               fail_q;
  logic               chk_pending_q;
  logic [26:0]        timer_q;

  logic [THETA_W-1:0] tgt_theta, cur_theta, pd_delta, pd_mag, pd_circ;
  logic               pd_left;
  logic [R_W-1:0]     tgt_r, rov_r;
  logic signed [7:0]  dr;
  logic [7:0]         abs_dr;
  logic               retrying, retry_ok, arrived_d;
  cmd_type_e          drv_type_d;
  logic [R_W-1:0]     drv_arg_d;

  assign tgt_theta = loc_theta(tgt_q);
  assign tgt_r     = loc_r(tgt_q);
  assign rov_r     = loc_r(rover_location);

  // Planning compares against the heading; judging compares against the
  // measured position, so one angle unit serves both phases.
  assign cur_theta = (state_q == ST_CALC) ? rover_heading : loc_theta(rover_location);

  polar_delta u_polar_delta (
    .target_theta_i  (tgt_theta),
    .current_theta_i (cur_theta),
    .delta_o         (pd_delta),
    .turn_left_o     (pd_left),
    .turn_mag_o      (pd_mag),
    .circ_dist_o     (pd_circ)
  );

`ifdef PLANNER_RETRY_EN
  assign retry_ok    = (retry_q < 2'(MAX_RETRIES));
  assign retry_count = retry_q;
`else
  assign retry_ok    = 1'b0;
  assign retry_count = 2'd0;
`endif

  // Drive planning and arrival test. The radius error is kept at 8-bit
  // signed width so a full 0..127 swing in either direction fits, and its
  // magnitude always fits back into the 7-bit argument field.
  always_comb begin
    retrying   = (retry_q != 2'd0);
    dr         = $signed({1'b0, tgt_r}) - $signed({1'b0, rov_r});
    abs_dr     = dr[7] ? 8'(-dr) : 8'(dr);
    drv_type_d = (retrying && dr[7]) ? CMD_DRIVE_REV : CMD_DRIVE_FWD;
    drv_arg_d  = retrying ? abs_dr[R_W-1:0] : tgt_r;
    arrived_d  = (abs_dr <= {1'b0, R_TOL}) && (pd_circ <= THETA_TOL);
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_arg   = cmd_arg_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign busy      = (state_q != ST_IDLE);

  // Main sequencer. done/fail default low each cycle so they only ever
  // pulse. A verdict is registered on the edge that enters CHECK, making
  // done/fail visible during the CHECK cycle itself. Commands stay on the
  // bus until accepted, and valid drops for a cycle after each transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tgt_q         <= '0;
      retry_q       <= 2'd0;
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= CMD_TURN_LEFT;
      cmd_arg_q     <= '0;
      drv_type_q    <= CMD_DRIVE_FWD;
      drv_arg_q     <= '0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      chk_pending_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !done_q && !fail_q) begin
            tgt_q   <= target_location;
            retry_q <= 2'd0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (tgt_theta >= THETA_LIMIT) begin
            fail_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            drv_type_q <= drv_type_d;
            drv_arg_q  <= drv_arg_d;
            if (pd_delta != '0) begin
              cmd_valid_q <= 1'b1;
              cmd_type_q  <= pd_left ? CMD_TURN_LEFT : CMD_TURN_RIGHT;
              cmd_arg_q   <= {{(R_W-THETA_W){1'b0}}, pd_mag};
              state_q     <= ST_SEND_TURN;
            end else if (drv_arg_d != '0) begin
              cmd_valid_q <= 1'b1;
              cmd_type_q  <= drv_type_d;
              cmd_arg_q   <= drv_arg_d;
              state_q     <= ST_SEND_DRIVE;
            end else begin
              chk_pending_q <= 1'b1;
              state_q       <= ST_CHECK;
            end
          end
        end
        ST_SEND_TURN: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= (drv_arg_q != '0) ? ST_SEND_DRIVE : ST_WAIT_MEAS;
          end
        end
        ST_SEND_DRIVE: begin
          if (!cmd_valid_q) begin
            cmd_valid_q <= 1'b1;
            cmd_type_q  <= drv_type_q;
            cmd_arg_q   <= drv_arg_q;
          end else if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= ST_WAIT_MEAS;
          end
        end
        ST_WAIT_MEAS: begin
          if (meas_valid) begin
            done_q  <= arrived_d;
            fail_q  <= !arrived_d && !retry_ok;
            if (!arrived_d && retry_ok) retry_q <= retry_q + 2'd1;
            state_q <= ST_CHECK;
          end else if (timer_q == TIMEOUT_CYCLES - 27'd1) begin
            fail_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 27'd1;
          end
        end
        ST_CHECK: begin
          if (chk_pending_q) begin
            chk_pending_q <= 1'b0;
            done_q        <= arrived_d;
            fail_q        <= !arrived_d && !retry_ok;
            if (!arrived_d && retry_ok) retry_q <= retry_q + 2'd1;
          end else begin
            state_q <= (done_q || fail_q) ? ST_IDLE : ST_CALC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_path_planner.sv
// ---------------------------------------------------------------------------
// tb_target_path_planner
// Purpose : Directed, table-driven bench for target_path_planner with a
//           shortened measurement timeout, plus hand-written sequences for
//           stalls, reset mid-handshake, timeout, retries and bad targets.
// ---------------------------------------------------------------------------
module tb_target_path_planner;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] targetLocation;
  logic [11:0] roverLocation;
  logic [4:0]  roverHeading;
  logic        measValid;
  logic        cmdReady;
  logic        cmdValid;
  logic [1:0]  cmdType;
  logic [6:0]  cmdArg;
  logic        busy;
  logic        done;
  logic        fail;
  logic [1:0]  retryCount;

  int total = 0;
  int bad   = 0;
  int validCycles = 0;
  logic [8:0] xferQ[$];

  typedef struct {
    logic [4:0] heading;
    logic [4:0] tgtTheta;
    logic [6:0] tgtR;
    logic [4:0] measTheta;
    logic [6:0] measR;
    logic       hasTurn;
    logic [1:0] turnType;
    logic [6:0] turnArg;
    logic [6:0] driveArg;
    logic       expDone;
  } vector_t;

  vector_t vectors[7];

  target_path_planner #(.TIMEOUT_CYCLES(27'd100)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .target_location (targetLocation),
    .rover_location  (roverLocation),
    .rover_heading   (roverHeading),
    .meas_valid      (measValid),
    .cmd_ready       (cmdReady),
    .cmd_valid       (cmdValid),
    .cmd_type        (cmdType),
    .cmd_arg         (cmdArg),
    .busy            (busy),
    .done            (done),
    .fail            (fail),
    .retry_count     (retryCount)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // Record every completed handshake and every cycle with valid raised.
  always @(posedge clock) begin
    if (!reset && cmdValid) begin
      validCycles <= validCycles + 1;
      if (cmdReady) xferQ.push_back({cmdType, cmdArg});
    end
  end

  // Hard stop in case a sequence wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] heading, input logic [11:0] target);
    roverHeading   = heading;
    targetLocation = target;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic runVector(input vector_t v);
    int base;
    int n;
    doReset();
    cmdReady      = 1'b1;
    roverLocation = {v.heading, 7'd0};
    base = xferQ.size();
    n    = v.hasTurn ? 2 : 1;
    applyStimulus(v.heading, {v.tgtTheta, v.tgtR});
    for (int c = 0; c < 40 && (xferQ.size() - base) < n; c++) tick();
    checkOutput("xferCount", xferQ.size() - base, n);
    if (v.hasTurn) begin
      checkOutput("turnType", xferQ[base][8:7], v.turnType);
      checkOutput("turnArg", xferQ[base][6:0], v.turnArg);
    end
    checkOutput("driveType", xferQ[base+n-1][8:7], 2'b10);
    checkOutput("driveArg", xferQ[base+n-1][6:0], v.driveArg);
    roverLocation = {v.measTheta, v.measR};
    measValid = 1'b1;
    tick();
    measValid = 1'b0;
    checkOutput("doneAfterMeas", done, v.expDone);
    checkOutput("busyInCheck", busy, 1);
  endtask

  initial begin
    int base;
    int vc;
    logic [1:0] retryType[3];
    logic [6:0] retryArg[3];
    logic [6:0] retryMeasR[3];

    // heading, tgtTheta, tgtR, measTheta, measR, hasTurn, turnType, turnArg, driveArg, expDone
    vectors[0] = '{5'd0,  5'd6,  7'd24, 5'd6,  7'd24, 1'b1, 2'b00, 7'd6,  7'd24, 1'b1};
    vectors[1] = '{5'd20, 5'd2,  7'd10, 5'd3,  7'd7,  1'b1, 2'b00, 7'd6,  7'd10, 1'b1};
    vectors[2] = '{5'd2,  5'd20, 7'd5,  5'd19, 7'd8,  1'b1, 2'b01, 7'd6,  7'd5,  1'b1};
    vectors[3] = '{5'd5,  5'd5,  7'd40, 5'd5,  7'd44, 1'b0, 2'b00, 7'd0,  7'd40, 1'b0};
    vectors[4] = '{5'd0,  5'd12, 7'd1,  5'd14, 7'd1,  1'b1, 2'b00, 7'd12, 7'd1,  1'b0};
    vectors[5] = '{5'd0,  5'd13, 7'd1,  5'd13, 7'd1,  1'b1, 2'b01, 7'd11, 7'd1,  1'b1};
    vectors[6] = '{5'd23, 5'd0,  7'd7,  5'd23, 7'd7,  1'b1, 2'b00, 7'd1,  7'd7,  1'b1};

    reset = 1'b1; start = 1'b0; targetLocation = '0; roverLocation = '0;
    roverHeading = '0; measValid = 1'b0; cmdReady = 1'b0;
    doReset();
    checkOutput("rstValid", cmdValid, 0);
    checkOutput("rstType", cmdType, 0);
    checkOutput("rstArg", cmdArg, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstFail", fail, 0);
    checkOutput("rstRetry", retryCount, 0);

    for (int i = 0; i < 7; i++) runVector(vectors[i]);

    // Stalled handshake: turn-left 8 held while ready is low, then reset
    // lands while the drive command is being offered.
    doReset();
    cmdReady = 1'b0;
    roverLocation = '0;
    applyStimulus(5'd0, {5'd8, 7'd10});
    checkOutput("calcValidLow", cmdValid, 0);
    checkOutput("busyAfterStart", busy, 1);
    tick();
    checkOutput("latencyValid", cmdValid, 1);
    checkOutput("stallType", cmdType, 0);
    checkOutput("stallArg", cmdArg, 8);
    base = xferQ.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stallValidHeld", cmdValid, 1);
      checkOutput("stallTypeHeld", cmdType, 0);
      checkOutput("stallArgHeld", cmdArg, 8);
    end
    checkOutput("noXferWhileStalled", xferQ.size() - base, 0);
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
    checkOutput("oneXfer", xferQ.size() - base, 1);
    checkOutput("validDropsAfterXfer", cmdValid, 0);
    tick();
    checkOutput("driveValid", cmdValid, 1);
    checkOutput("driveType", cmdType, 2);
    checkOutput("driveArg", cmdArg, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midRstValid", cmdValid, 0);
    checkOutput("midRstType", cmdType, 0);
    checkOutput("midRstArg", cmdArg, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstFail", fail, 0);
    checkOutput("midRstRetry", retryCount, 0);
    checkOutput("stillOneXfer", xferQ.size() - base, 1);

    // Measurement timeout: fail exactly 100 cycles after entering WAIT_MEAS.
    doReset();
    cmdReady = 1'b1;
    roverLocation = '0;
    base = xferQ.size();
    applyStimulus(5'd0, {5'd0, 7'd5});
    tick();
    tick();
    checkOutput("timeoutDriveXfer", xferQ.size() - base, 1);
    for (int i = 0; i < 99; i++) tick();
    checkOutput("noEarlyTimeout", fail, 0);
    checkOutput("busyWhileWaiting", busy, 1);
    tick();
    checkOutput("timeoutFail", fail, 1);
    checkOutput("timeoutBusyDrops", busy, 0);
    targetLocation = {5'd4, 7'd4};
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("startWithFailIgnored", busy, 0);
    checkOutput("failIsPulse", fail, 0);
    measValid = 1'b1;
    tick();
    measValid = 1'b0;
    checkOutput("idleMeasIgnoredDone", done, 0);
    checkOutput("idleMeasIgnoredBusy", busy, 0);

    // Missed target: r = 20 measured against target r = 32.
    doReset();
    cmdReady = 1'b1;
    roverLocation = '0;
    applyStimulus(5'd0, {5'd0, 7'd32});
    tick();
    checkOutput("firstDriveArg", cmdArg, 32);
    tick();
    roverLocation = {5'd0, 7'd20};
    measValid = 1'b1;
    tick();
    measValid = 1'b0;
`ifdef PLANNER_RETRY_EN
    checkOutput("retry1Count", retryCount, 1);
    checkOutput("retry1NoFail", fail, 0);
    retryType  = '{2'b10, 2'b11, 2'b10};
    retryArg   = '{7'd12, 7'd8,  7'd12};
    retryMeasR = '{7'd40, 7'd20, 7'd20};
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      checkOutput("retryDriveValid", cmdValid, 1);
      checkOutput("retryDriveType", cmdType, retryType[k]);
      checkOutput("retryDriveArg", cmdArg, retryArg[k]);
      tick();
      roverLocation = {5'd0, retryMeasR[k]};
      measValid = 1'b1;
      tick();
      measValid = 1'b0;
      if (k < 2) begin
        checkOutput("retryCountStep", retryCount, k + 2);
        checkOutput("retryNoFail", fail, 0);
      end else begin
        checkOutput("retriesExhaustedFail", fail, 1);
        checkOutput("retriesExhaustedCount", retryCount, 3);
      end
    end
`else
    retryType  = '{2'b10, 2'b10, 2'b10};
    retryArg   = '{7'd0, 7'd0, 7'd0};
    retryMeasR = '{7'd0, 7'd0, 7'd0};
    checkOutput("missFailNoRetry", fail, 1);
    checkOutput("missRetryTied", retryCount, 0);
    checkOutput("missNoDone", done, 0);
`endif
    tick();
    checkOutput("missBusyDrops", busy, 0);

    // Out-of-range target theta: fail pulse, no command ever offered.
    doReset();
    vc = validCycles;
    applyStimulus(5'd0, {5'd25, 7'd10});
    tick();
    checkOutput("badThetaFail", fail, 1);
    checkOutput("badThetaIdle", busy, 0);
    tick();
    tick();
    checkOutput("badThetaFailPulse", fail, 0);
    checkOutput("badThetaNoValid", validCycles - vc, 0);

    // Already at target: no commands, done straight from the check.
    doReset();
    base = xferQ.size();
    roverLocation = {5'd3, 7'd0};
    applyStimulus(5'd3, {5'd3, 7'd0});
    for (int c = 0; c < 6 && !done; c++) tick();
    checkOutput("zeroMoveDone", done, 1);
    checkOutput("zeroMoveNoXfer", xferQ.size() - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
